// File: rtl/audio_gain_stage.sv
// rtl/audio_gain_stage.sv - stereo Q2.14 gain stage with saturation and optional gain ramp
//
// Scales a packed stereo sample by a per-channel unsigned Q2.14 gain.
// data[DWIDTH-1:DWIDTH/2] is left and data[DWIDTH/2-1:0] is right. Each half is
// a signed two's complement word.
//
// Optional feature: define GAIN_RAMP_EN to compile in the per-channel ramp FSM.
// Without it the effective gain jumps to the target on every accepted sample
// and gain_busy is tied low.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   s_axis_data   stereo input sample
//   s_axis_valid  input sample valid
//   s_axis_ready  input accepted when high together with s_axis_valid
//   m_axis_data   scaled, saturated stereo output sample
//   m_axis_valid  output sample valid
//   m_axis_ready  downstream ready
//   gain_l/gain_r target gain per channel, unsigned Q2.14 (0x4000 = unity)
//   mute          forces the target gain of both channels to zero
//   gain_busy     high while either channel's effective gain is off target
//
// Timing: a sample accepted at edge N is presented on m_axis after edge N+2.
// The pipeline is s1 (input capture and gain update), s2 (product) and the
// output register (shift and saturate). The whole pipeline advances only
// when the output register is empty or being drained.

module audio_gain_stage #(
    parameter int DWIDTH     = 48,
    parameter int GAIN_WIDTH = 16,
    parameter int RAMP_STEP  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DWIDTH-1:0]     s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    output logic [DWIDTH-1:0]     m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    input  logic [GAIN_WIDTH-1:0] gain_l,
    input  logic [GAIN_WIDTH-1:0] gain_r,
    input  logic                  mute,
    output logic                  gain_busy
);

    localparam int CW   = DWIDTH / 2;            // channel word width
    localparam int PW   = CW + GAIN_WIDTH + 1;   // signed sample x zero-extended gain
    localparam int FRAC = GAIN_WIDTH - 2;        // Q2.x fractional bits

    logic                        ce;
    logic                        accept;
    logic [GAIN_WIDTH-1:0]       tgt_l;
    logic [GAIN_WIDTH-1:0]       tgt_r;
    logic [GAIN_WIDTH-1:0]       cur_l;
    logic [GAIN_WIDTH-1:0]       cur_r;
    logic [GAIN_WIDTH-1:0]       next_l;
    logic [GAIN_WIDTH-1:0]       next_r;

    logic                        s1_valid;
    logic signed [CW-1:0]        s1_l;
    logic signed [CW-1:0]        s1_r;
    logic                        s2_valid;
    logic signed [PW-1:0]        s2_l;
    logic signed [PW-1:0]        s2_r;

    assign ce           = !m_axis_valid || m_axis_ready;
    assign s_axis_ready = reset && ce;
    assign accept       = s_axis_valid && s_axis_ready;

    // Targets are only consumed on an accepted transfer, so a gain or mute
    // change between samples is picked up by the next accepted sample.
    assign tgt_l = mute ? '0 : gain_l;
    assign tgt_r = mute ? '0 : gain_r;

    // Signed sample times gain, with the gain zero-extended so 0x8000..0xFFFF
    // stay positive. The true product always fits in PW bits.
    function automatic logic signed [PW-1:0] scale(
        input logic signed [CW-1:0]   x,
        input logic [GAIN_WIDTH-1:0]  g
    );
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ge;
        xe = PW'(x);
        ge = $signed(PW'({1'b0, g}));
        return xe * ge;
    endfunction

    // Arithmetic shift (floor) back to sample scale, then clamp to the
    // channel's signed range. In range means all bits above the channel
    // sign bit equal the sign bit.
    function automatic logic [CW-1:0] saturate(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] sh;
        logic [CW-1:0]        r;
        sh = p >>> FRAC;
        if ((sh[PW-1:CW-1] == {(PW-CW+1){1'b0}}) ||
            (sh[PW-1:CW-1] == {(PW-CW+1){1'b1}})) begin
            r = sh[CW-1:0];
        end else if (sh[PW-1]) begin
            r = {1'b1, {(CW-1){1'b0}}};
        end else begin
            r = {1'b0, {(CW-1){1'b1}}};
        end
        return r;
    endfunction

`ifdef GAIN_RAMP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } ramp_state_t;

    localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);

    ramp_state_t state_l;
    ramp_state_t state_r;

    // Direction comes from comparing against the target seen on this
    // transfer, not from the stored state, so a retarget mid-ramp reverses
    // direction on the very sample that carries it.
    function automatic logic [GAIN_WIDTH-1:0] ramp_next(
        input logic [GAIN_WIDTH-1:0] cur,
        input logic [GAIN_WIDTH-1:0] tgt
    );
        logic [GAIN_WIDTH-1:0] r;
        r = cur;
        if (cur < tgt) begin
            r = ((tgt - cur) <= STEP) ? tgt : (cur + STEP);
        end else if (cur > tgt) begin
            r = ((cur - tgt) <= STEP) ? tgt : (cur - STEP);
        end
        return r;
    endfunction

    function automatic ramp_state_t ramp_state(
        input logic [GAIN_WIDTH-1:0] cur,
        input logic [GAIN_WIDTH-1:0] tgt
    );
        ramp_state_t s;
        if (cur < tgt) begin
            s = UP;
        end else if (cur > tgt) begin
            s = DOWN;
        end else begin
            s = IDLE;
        end
        return s;
    endfunction

    assign next_l = ramp_next(cur_l, tgt_l);
    assign next_r = ramp_next(cur_r, tgt_r);

    // State and busy are re-evaluated against the updated gain so busy
    // drops on the same edge that lands the final step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_l   <= IDLE;
            state_r   <= IDLE;
            gain_busy <= 1'b0;
        end else if (accept) begin
            state_l   <= ramp_state(next_l, tgt_l);
            state_r   <= ramp_state(next_r, tgt_r);
            gain_busy <= (ramp_state(next_l, tgt_l) != IDLE) ||
                         (ramp_state(next_r, tgt_r) != IDLE);
        end
    end
`else
    assign next_l    = tgt_l;
    assign next_r    = tgt_r;
    assign gain_busy = 1'b0;
`endif

    // cur_x is updated on the accept edge, and s1 multiplies by it one edge
    // later. No further accept can intervene, so each sample sees its own
    // updated gain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_l        <= '0;
            cur_r        <= '0;
            s1_valid     <= 1'b0;
            s1_l         <= '0;
            s1_r         <= '0;
            s2_valid     <= 1'b0;
            s2_l         <= '0;
            s2_r         <= '0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
        end else begin
            if (accept) begin
                cur_l <= next_l;
                cur_r <= next_r;
            end
            if (ce) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_l <= s_axis_data[DWIDTH-1:CW];
                    s1_r <= s_axis_data[CW-1:0];
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_l <= scale(s1_l, cur_l);
                    s2_r <= scale(s1_r, cur_r);
                end
                m_axis_valid <= s2_valid;
                if (s2_valid) begin
                    m_axis_data <= {saturate(s2_l), saturate(s2_r)};
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_gain_stage.sv
// tb/tb_audio_gain_stage.sv - scoreboard bench for audio_gain_stage
module tb_audio_gain_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] s_axis_data;
    logic        s_axis_valid;
    logic        s_axis_ready;
    logic [47:0] m_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [15:0] gain_l;
    logic [15:0] gain_r;
    logic        mute;
    logic        gain_busy;

    always #5 clk = ~clk;

    audio_gain_stage dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .gain_l       (gain_l),
        .gain_r       (gain_r),
        .mute         (mute),
        .gain_busy    (gain_busy)
    );

    logic [47:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        bp_en    = 1'b0;
    logic        busy_seen = 1'b0;

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input string nm, input logic [47:0] d, input logic [15:0] gl,
                        input logic [15:0] gr, input logic m, input logic [47:0] e);
        int n;
        n = 0;
        @(negedge clk);
        s_axis_data  = d;
        gain_l       = gl;
        gain_r       = gr;
        mute         = m;
        s_axis_valid = 1'b1;
        while (!s_axis_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout %s: s_axis_ready stayed low", nm);
            s_axis_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            name_q.push_back(nm);
            @(posedge clk);
            #1;
            s_axis_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 48'(exp_q.size()), 48'd0);
    endtask

    // Downstream ready: low for 10 of every 50 cycles when backpressure is on.
    initial begin
        int bp_cnt;
        bp_cnt = 0;
        m_axis_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bp_cnt++;
            m_axis_ready = !bp_en || ((bp_cnt % 50) >= 10);
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks that
    // a stalled output holds its data.
    initial begin
        logic [47:0] held;
        logic        stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stalled = 1'b0;
            end else begin
                if (gain_busy) busy_seen = 1'b1;
                if (stalled) begin
                    check("stall_hold_data", m_axis_data, held);
                    check("stall_hold_valid", 48'(m_axis_valid), 48'd1);
                end
                stalled = m_axis_valid && !m_axis_ready;
                held    = m_axis_data;
                if (m_axis_valid && m_axis_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h expected none", m_axis_data);
                    end else begin
                        check(name_q.pop_front(), m_axis_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int          lat;
        logic [47:0] lfsr;
        logic [47:0] e;

        reset        = 1'b0;
        s_axis_data  = '0;
        s_axis_valid = 1'b0;
        gain_l       = 16'h4000;
        gain_r       = 16'h4000;
        mute         = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_m_valid", 48'(m_axis_valid), 48'd0);
        check("rst_m_data", m_axis_data, 48'd0);
        check("rst_s_ready", 48'(s_axis_ready), 48'd0);
        check("rst_busy", 48'(gain_busy), 48'd0);
        reset = 1'b1;

`ifdef GAIN_RAMP_EN
        for (int k = 1; k <= 256; k++) begin
            e = {24'(32'h1000 * k), 24'(32'h1000 * k)};
            send("ramp_up", 48'h100000_100000, 16'h4000, 16'h4000, 1'b0, e);
            if (k == 255) check("busy_k255", 48'(gain_busy), 48'd1);
            if (k == 256) check("busy_k256", 48'(gain_busy), 48'd0);
        end
        send("ramp_settled", 48'h100000_100000, 16'h4000, 16'h4000, 1'b0, 48'h100000_100000);
        drain();
`endif

        // Unity gain, empty pipeline: latency of two edges after acceptance.
        send("unity", 48'h123456_EDCBAA, 16'h4000, 16'h4000, 1'b0, 48'h123456_EDCBAA);
        lat = 0;
        while (!m_axis_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 48'(lat), 48'd2);
        drain();

`ifndef GAIN_RAMP_EN
        // Back-to-back samples, each with its own gain.
        send("sat_ffff_max", 48'h7FFFFF_800000, 16'hFFFF, 16'hFFFF, 1'b0, 48'h7FFFFF_800000);
        send("sat_ffff_small", 48'h000001_FFFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 48'h000003_FFFFFC);
        send("half_floor", 48'h100000_FFFFFF, 16'h2000, 16'h2000, 1'b0, 48'h080000_FFFFFF);
        send("x2_pos_sat", 48'h400000_123456, 16'h8000, 16'h0000, 1'b0, 48'h7FFFFF_000000);
        send("x2_neg_edge", 48'hC00000_B00000, 16'h8000, 16'h8000, 1'b0, 48'h800000_800000);
        send("mute", 48'h123456_654321, 16'h4000, 16'h4000, 1'b1, 48'h000000_000000);
        send("min_gain", 48'h7FFFFF_004000, 16'h4000, 16'h0001, 1'b0, 48'h7FFFFF_000001);
        send("indep_lr", 48'h000010_000010, 16'h1000, 16'h4000, 1'b0, 48'h000004_000010);
        send("zero_gain", 48'h7FFFFF_800000, 16'h0000, 16'h0000, 1'b0, 48'h000000_000000);
        drain();
`endif

        // 1000 LFSR samples at unity with periodic backpressure.
        bp_en = 1'b1;
        lfsr  = 48'hACE1_2345_6789;
        for (int i = 0; i < 1000; i++) begin
            lfsr = {lfsr[46:0], lfsr[47] ^ lfsr[46] ^ lfsr[20] ^ lfsr[19]};
            send("bp_stream", lfsr, 16'h4000, 16'h4000, 1'b0, lfsr);
        end
        drain();
        bp_en = 1'b0;

`ifdef GAIN_RAMP_EN
        // Mute ramps down 64 per sample; unmute at sample 100 reverses at once.
        for (int k = 1; k <= 99; k++) begin
            e = {24'(32'h100000 - 32'h1000 * k), 24'(32'h100000 - 32'h1000 * k)};
            send("mute_ramp", 48'h100000_100000, 16'h4000, 16'h4000, 1'b1, e);
        end
        send("unmute_reverse", 48'h100000_100000, 16'h4000, 16'h4000, 1'b0, 48'h09E000_09E000);
        check("busy_reverse", 48'(gain_busy), 48'd1);
        drain();
`endif

        // Reset mid-stream: in-flight samples are discarded.
        send("flushed_a", 48'h111111_222222, 16'h4000, 16'h4000, 1'b0, 48'h111111_222222);
        send("flushed_b", 48'h333333_444444, 16'h4000, 16'h4000, 1'b0, 48'h333333_444444);
        reset = 1'b0;
        exp_q.delete();
        name_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_valid", 48'(m_axis_valid), 48'd0);
        check("midrst_s_ready", 48'(s_axis_ready), 48'd0);
        check("midrst_m_data", m_axis_data, 48'd0);
        check("midrst_busy", 48'(gain_busy), 48'd0);
        reset = 1'b1;
`ifdef GAIN_RAMP_EN
        send("post_reset", 48'h100000_100000, 16'h4000, 16'h4000, 1'b0, 48'h001000_001000);
`else
        send("post_reset", 48'h100000_100000, 16'h4000, 16'h4000, 1'b0, 48'h100000_100000);
`endif
        drain();
        repeat (5) @(negedge clk);

`ifndef GAIN_RAMP_EN
        check("busy_never", 48'(busy_seen), 48'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
